// File: rtl/stage_id_queue.sv
// Decode stage with an instruction queue in front of a registered decode output.
// Operands resolve through prioritised bypass channels; load-use hazards hold the head.
module stage_id_queue #(
    parameter int DEPTH   = 4,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    input  logic [NUM_FWD-1:0]       fwd_valid,
    input  logic [NUM_FWD-1:0]       fwd_load,
    input  logic [5*NUM_FWD-1:0]     fwd_addr,
    input  logic [32*NUM_FWD-1:0]    fwd_data,
    output logic [4:0]               rf_addr1,
    output logic [4:0]               rf_addr2,
    input  logic [31:0]              rf_data1,
    input  logic [31:0]              rf_data2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_rs1_data,
    output logic [31:0]              out_rs2_data,
    output logic [31:0]              out_imm,
    output logic [6:0]               out_opcode,
    output logic [2:0]               out_func3,
    output logic                     out_func7b5,
    output logic [4:0]               out_rd_addr,
    output logic                     out_rd_write,
    output logic                     out_rd_load,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic           out_valid_q, out_valid_d;
    logic [31:0]    out_pc_q, out_pc_d, out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
    logic [31:0]    out_imm_q, out_imm_d;
    logic [6:0]     out_opcode_q, out_opcode_d;
    logic [2:0]     out_func3_q, out_func3_d;
    logic           out_func7b5_q, out_func7b5_d;
    logic [4:0]     out_rd_addr_q, out_rd_addr_d;
    logic           out_rd_write_q, out_rd_write_d, out_rd_load_q, out_rd_load_d;

    logic [4:0]  ch_addr [NUM_FWD];
    logic [31:0] ch_data [NUM_FWD];

    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_ch
            assign ch_addr[gi] = fwd_addr[5*gi +: 5];
            assign ch_data[gi] = fwd_data[32*gi +: 32];
        end
    endgenerate

    logic [31:0] head_inst, head_pc, imm;
    logic        use1, use2, rd_write, rd_load;
    logic [31:0] opnd1, opnd2;
    logic        haz1, haz2, hazard, has_head, issue, push;

    assign head_inst = inst_mem[rd_ptr_q];
    assign head_pc   = pc_mem[rd_ptr_q];
    assign rf_addr1  = head_inst[19:15];
    assign rf_addr2  = head_inst[24:20];

    always_comb begin
        imm      = '0;
        use1     = 1'b0;
        use2     = 1'b0;
        rd_write = 1'b0;
        rd_load  = 1'b0;
        case (head_inst[6:0])
            OP_LUI, OP_AUIPC: begin
                imm      = {head_inst[31:12], 12'b0};
                rd_write = 1'b1;
            end
            OP_JAL: begin
                imm      = {{12{head_inst[31]}}, head_inst[19:12], head_inst[20], head_inst[30:21], 1'b0};
                rd_write = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                imm      = {{20{head_inst[31]}}, head_inst[31:20]};
                use1     = 1'b1;
                rd_write = 1'b1;
                rd_load  = (head_inst[6:0] == OP_LOAD);
                // Shift amounts are unsigned; bit 30 selects arithmetic shift, not the sign
                if (head_inst[6:0] == OP_IMM && head_inst[13:12] == 2'b01)
                    imm = {27'b0, head_inst[24:20]};
            end
            OP_BRANCH: begin
                imm  = {{20{head_inst[31]}}, head_inst[7], head_inst[30:25], head_inst[11:8], 1'b0};
                use1 = 1'b1;
                use2 = 1'b1;
            end
            OP_STORE: begin
                imm  = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
                use1 = 1'b1;
                use2 = 1'b1;
            end
            OP_OP: begin
                use1     = 1'b1;
                use2     = 1'b1;
                rd_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Scan from the lowest priority upward so the youngest matching producer wins.
    always_comb begin
        opnd1 = '0;
        opnd2 = '0;
        haz1  = 1'b0;
        haz2  = 1'b0;
        if (use1 && rf_addr1 != 5'd0) begin
            opnd1 = rf_data1;
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (fwd_valid[i] && ch_addr[i] == rf_addr1) begin
                    opnd1 = ch_data[i];
                    haz1  = fwd_load[i];
                end
            end
        end
        if (use2 && rf_addr2 != 5'd0) begin
            opnd2 = rf_data2;
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (fwd_valid[i] && ch_addr[i] == rf_addr2) begin
                    opnd2 = ch_data[i];
                    haz2  = fwd_load[i];
                end
            end
        end
    end

    assign hazard   = haz1 | haz2;
    assign has_head = (count_q != '0);
    assign in_ready = (count_q < DEPTH_C);
    assign push     = in_valid && in_ready && !flush;
    assign issue    = has_head && !hazard && (!out_valid_q || out_ready) && !flush;

    always_comb begin
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        stall_d        = stall_q;
        out_valid_d    = out_valid_q;
        out_pc_d       = out_pc_q;
        out_rs1_d      = out_rs1_q;
        out_rs2_d      = out_rs2_q;
        out_imm_d      = out_imm_q;
        out_opcode_d   = out_opcode_q;
        out_func3_d    = out_func3_q;
        out_func7b5_d  = out_func7b5_q;
        out_rd_addr_d  = out_rd_addr_q;
        out_rd_write_d = out_rd_write_q;
        out_rd_load_d  = out_rd_load_q;
        if (has_head && hazard && stall_q != '1)
            stall_d = stall_q + CNT_W'(1);
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + AW'(1);
            if (issue) begin
                rd_ptr_d       = rd_ptr_q + AW'(1);
                out_valid_d    = 1'b1;
                out_pc_d       = head_pc;
                out_rs1_d      = opnd1;
                out_rs2_d      = opnd2;
                out_imm_d      = imm;
                out_opcode_d   = head_inst[6:0];
                out_func3_d    = head_inst[14:12];
                out_func7b5_d  = head_inst[30];
                out_rd_addr_d  = head_inst[11:7];
                out_rd_write_d = rd_write;
                out_rd_load_d  = rd_load;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
            case ({push, issue})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= in_pc;
            inst_mem[wr_ptr_q] <= in_inst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            stall_q        <= '0;
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_rs1_q      <= '0;
            out_rs2_q      <= '0;
            out_imm_q      <= '0;
            out_opcode_q   <= '0;
            out_func3_q    <= '0;
            out_func7b5_q  <= 1'b0;
            out_rd_addr_q  <= '0;
            out_rd_write_q <= 1'b0;
            out_rd_load_q  <= 1'b0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            stall_q        <= stall_d;
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_rs1_q      <= out_rs1_d;
            out_rs2_q      <= out_rs2_d;
            out_imm_q      <= out_imm_d;
            out_opcode_q   <= out_opcode_d;
            out_func3_q    <= out_func3_d;
            out_func7b5_q  <= out_func7b5_d;
            out_rd_addr_q  <= out_rd_addr_d;
            out_rd_write_q <= out_rd_write_d;
            out_rd_load_q  <= out_rd_load_d;
        end
    end

    assign occupancy    = count_q;
    assign stall_cnt    = stall_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_rs1_data = out_rs1_q;
    assign out_rs2_data = out_rs2_q;
    assign out_imm      = out_imm_q;
    assign out_opcode   = out_opcode_q;
    assign out_func3    = out_func3_q;
    assign out_func7b5  = out_func7b5_q;
    assign out_rd_addr  = out_rd_addr_q;
    assign out_rd_write = out_rd_write_q;
    assign out_rd_load  = out_rd_load_q;

endmodule

// File: tb/tb_stage_id_queue.sv
// Directed bench for stage_id_queue: a queue-based reference model checked every cycle,
// plus hand-computed expectations for streaming, forwarding, stalls, full, flush and reset.
module tb_stage_id_queue;
    localparam int DEPTH   = 4;
    localparam int NUM_FWD = 2;
    localparam int CNT_W   = 3;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_inst, rf_data1, rf_data2;
    logic [NUM_FWD-1:0] fwd_valid, fwd_load;
    logic [5*NUM_FWD-1:0] fwd_addr;
    logic [32*NUM_FWD-1:0] fwd_data;
    logic [4:0] rf_addr1, rf_addr2, out_rd_addr;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [6:0] out_opcode;
    logic [2:0] out_func3;
    logic out_func7b5, out_rd_write, out_rd_load;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CNT_W-1:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    stage_id_queue #(.DEPTH(DEPTH), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .fwd_valid(fwd_valid), .fwd_load(fwd_load), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_opcode(out_opcode), .out_func3(out_func3), .out_func7b5(out_func7b5),
        .out_rd_addr(out_rd_addr), .out_rd_write(out_rd_write), .out_rd_load(out_rd_load),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return {27'b0, a} * 32'h0101_0101 + 32'h100;
    endfunction
    assign rf_data1 = rf_val(rf_addr1);
    assign rf_data2 = rf_val(rf_addr2);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t mq[$];
    bit mo_valid, mo_wr, mo_ld;
    logic [31:0] mo_pc, mo_inst, mo_rs1, mo_rs2, mo_imm;
    int m_stall;

    function automatic void mdec(input logic [31:0] w, output logic [31:0] imm,
                                 output bit u1, output bit u2, output bit wr, output bit ld);
        logic [31:0] sx;
        sx = $signed(w) >>> 20;
        imm = 0; u1 = 0; u2 = 0; wr = 0; ld = 0;
        case (w[6:0])
            7'h37, 7'h17: begin imm = w & 32'hFFFF_F000; wr = 1; end
            7'h6F: begin
                imm = (w[31] ? 32'hFFF0_0000 : 32'h0) | (w & 32'h000F_F000)
                    | (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
                wr = 1;
            end
            7'h67, 7'h03: begin imm = sx; u1 = 1; wr = 1; ld = (w[6:0] == 7'h03); end
            7'h13: begin
                imm = (w[14:12] == 3'b001 || w[14:12] == 3'b101) ? ((w >> 20) & 32'h1F) : sx;
                u1 = 1; wr = 1;
            end
            7'h63: begin
                imm = (w[31] ? 32'hFFFF_F000 : 32'h0) | (((w >> 7) & 32'h1) << 11)
                    | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
                u1 = 1; u2 = 1;
            end
            7'h23: begin imm = (sx & ~32'h1F) | ((w >> 7) & 32'h1F); u1 = 1; u2 = 1; end
            7'h33: begin u1 = 1; u2 = 1; wr = 1; end
            default: ;
        endcase
    endfunction

    function automatic void mres(input logic [4:0] rs, input bit u, output logic [31:0] v, output bit hz);
        v = 0; hz = 0;
        if (!u || rs == 0) return;
        v = rf_val(rs);
        for (int i = 0; i < NUM_FWD; i++) begin
            if (fwd_valid[i] && fwd_addr[5*i +: 5] == rs) begin
                v = fwd_data[32*i +: 32];
                hz = fwd_load[i];
                return;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mo_valid = 0; mo_wr = 0; mo_ld = 0; m_stall = 0;
            mo_pc = 0; mo_inst = 0; mo_rs1 = 0; mo_rs2 = 0; mo_imm = 0;
        end else begin : step
            bit u1, u2, wr, ld, hz1, hz2, iss, rdy;
            logic [31:0] v1, v2, imm;
            rdy = mq.size() < DEPTH;
            iss = 0;
            if (mq.size() > 0) begin
                mdec(mq[0].inst, imm, u1, u2, wr, ld);
                mres(mq[0].inst[19:15], u1, v1, hz1);
                mres(mq[0].inst[24:20], u2, v2, hz2);
                if (hz1 || hz2) begin
                    if (m_stall < SAT) m_stall++;
                end else begin
                    iss = !mo_valid || out_ready;
                end
            end
            if (flush) begin
                mq.delete();
                mo_valid = 0;
            end else begin
                if (iss) begin
                    mo_pc = mq[0].pc; mo_inst = mq[0].inst; mo_rs1 = v1; mo_rs2 = v2;
                    mo_imm = imm; mo_wr = wr; mo_ld = ld; mo_valid = 1;
                    void'(mq.pop_front());
                end else if (out_ready) begin
                    mo_valid = 0;
                end
                if (in_valid && rdy) mq.push_back('{in_pc, in_inst});
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("occupancy", occupancy, mq.size());
            chk("in_ready", in_ready, mq.size() < DEPTH);
            chk("out_valid", out_valid, mo_valid);
            chk("stall_cnt", stall_cnt, m_stall);
            if (mq.size() > 0) begin
                chk("rf_addr1", rf_addr1, mq[0].inst[19:15]);
                chk("rf_addr2", rf_addr2, mq[0].inst[24:20]);
            end
            if (mo_valid) begin
                chk("out_pc", out_pc, mo_pc);
                chk("out_rs1", out_rs1_data, mo_rs1);
                chk("out_rs2", out_rs2_data, mo_rs2);
                chk("out_imm", out_imm, mo_imm);
                chk("out_opcode", out_opcode, mo_inst[6:0]);
                chk("out_func3", out_func3, mo_inst[14:12]);
                chk("out_func7b5", out_func7b5, mo_inst[30]);
                chk("out_rd_addr", out_rd_addr, mo_inst[11:7]);
                chk("out_rd_write", out_rd_write, mo_wr);
                chk("out_rd_load", out_rd_load, mo_ld);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] addi(input int rd, input int rs, input int imm);
        return {12'(imm), 5'(rs), 3'b000, 5'(rd), 7'h13};
    endfunction
    function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction

    task automatic push(input logic [31:0] w);
        int n = 0;
        in_inst = w; in_pc = pc_ctr; in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(posedge clk); #2; n++; end
        if (n >= 50) begin
            n_vec++; n_err++;
            $display("FAIL push_timeout: in_ready stuck at %0b, required 1", in_ready);
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
        $display("push pc=%h inst=%h", in_pc, w);
        pc_ctr += 4;
    endtask

    task automatic drain();
        int n = 0;
        while ((occupancy != 0 || out_valid) && n < 30) begin @(posedge clk); #2; n++; end
        chk("drain_in_time", n < 30, 1'b1);
    endtask

    task automatic set_ch(input int i, input bit v, input bit ld, input logic [4:0] a, input logic [31:0] d);
        fwd_valid[i] = v; fwd_load[i] = ld; fwd_addr[5*i +: 5] = a; fwd_data[32*i +: 32] = d;
    endtask

    logic [31:0] dec_tab [11];

    initial begin
        rst_n = 1'b0; flush = 0; in_valid = 0; in_pc = 0; in_inst = 0; out_ready = 0;
        fwd_valid = 0; fwd_load = 0; fwd_addr = 0; fwd_data = 0;
        #3;
        chk("rst_occ", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", stall_cnt, 0);
        @(posedge clk); #2; rst_n = 1'b1;

        // Back-to-back stream of addi x1,x0,k
        in_valid = 1; out_ready = 1;
        for (int k = 0; k < 8; k++) begin
            in_inst = addi(1, 0, k); in_pc = pc_ctr; pc_ctr += 4;
            @(posedge clk); #2;
            $display("stream k=%0d occ=%0d out_valid=%0b imm=%0d", k, occupancy, out_valid, out_imm);
            chk("stream_occ", occupancy, 1);
            chk("stream_valid", out_valid, k > 0);
            if (k > 0) chk("stream_imm", out_imm, k - 1);
        end
        in_valid = 0;
        @(posedge clk); #2;
        chk("stream_last_valid", out_valid, 1);
        chk("stream_last_imm", out_imm, 7);
        drain();

        // Decode of every opcode class, including shifts with bit 30 set
        dec_tab = '{32'hDEADB0B7, 32'h87654217, 32'hF0F0F0EF, 32'h80012067, 32'hFE529CE3,
                    32'hA5A5A503, 32'hC3C3C3A3, 32'h84211093, 32'h99999933, 32'h1234567F,
                    {7'b0100000, 5'd3, 5'd2, 3'b101, 5'd4, 7'h13}};
        foreach (dec_tab[i]) push(dec_tab[i]);
        @(posedge clk); #2;
        chk("srai_imm", out_imm, 3);
        chk("srai_func3", out_func3, 5);
        chk("srai_f7b5", out_func7b5, 1);
        drain();

        // Forwarding priority
        set_ch(0, 1, 0, 5'd1, 32'hAAAA); set_ch(1, 1, 0, 5'd1, 32'hBBBB);
        push(add(3, 1, 2)); @(posedge clk); #2;
        chk("fwd_a_rs1", out_rs1_data, 32'hAAAA);
        chk("fwd_a_rs2", out_rs2_data, 32'h0202_0302);
        set_ch(1, 1, 0, 5'd2, 32'h1234);
        push(add(3, 1, 2)); @(posedge clk); #2;
        chk("fwd_b_rs1", out_rs1_data, 32'hAAAA);
        chk("fwd_b_rs2", out_rs2_data, 32'h1234);
        set_ch(1, 1, 1, 5'd1, 32'hBBBB);
        push(add(3, 1, 2)); @(posedge clk); #2;
        chk("fwd_c_issued", out_valid, 1);
        chk("fwd_c_rs1", out_rs1_data, 32'hAAAA);
        drain();

        // x0 and unused source fields never stall
        set_ch(0, 1, 1, 5'd0, 32'h0); set_ch(1, 0, 0, 5'd0, 32'h0);
        push(add(8, 0, 0));
        set_ch(0, 1, 1, 5'd9, 32'h0);
        push(32'h0004_83B7);
        push(addi(6, 1, 9));
        drain();
        chk("no_false_stall", stall_cnt, 0);

        // Load-use: three stalled cycles then issue with the forwarded value
        set_ch(0, 1, 1, 5'd4, 32'hDEAD);
        push(add(5, 4, 0));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            chk("lu_held", out_valid, 0);
        end
        set_ch(0, 1, 0, 5'd4, 32'h55);
        @(posedge clk); #2;
        $display("load-use issue rs1=%h stall_cnt=%0d", out_rs1_data, stall_cnt);
        chk("lu_issue", out_valid, 1);
        chk("lu_rs1", out_rs1_data, 32'h55);
        chk("lu_rs2", out_rs2_data, 0);
        chk("lu_stall3", stall_cnt, 3);
        set_ch(0, 1, 1, 5'd4, 32'hDEAD);
        push(add(5, 4, 0));
        repeat (6) begin @(posedge clk); #2; end
        chk("stall_saturate", stall_cnt, SAT);
        set_ch(0, 0, 0, 5'd0, 32'h0);
        drain();

        // Full queue with out_ready low
        out_ready = 0;
        for (int k = 0; k < 5; k++) push(addi(10, 0, 100 + k));
        chk("full_occ", occupancy, 4);
        chk("full_ready", in_ready, 0);
        chk("full_ovalid", out_valid, 1);
        in_valid = 1; in_inst = addi(10, 0, 105); in_pc = pc_ctr;
        repeat (2) begin
            @(posedge clk); #2;
            chk("full_hold_occ", occupancy, 4);
        end
        out_ready = 1;
        push(addi(10, 0, 105));
        drain();

        // Flush with three queued and a valid output
        out_ready = 0;
        for (int k = 0; k < 4; k++) push(addi(11, 0, 200 + k));
        chk("pre_flush_occ", occupancy, 3);
        in_valid = 1; in_inst = addi(12, 0, 300); in_pc = pc_ctr; flush = 1;
        @(posedge clk); #2;
        flush = 0; in_valid = 0;
        chk("flush_occ", occupancy, 0);
        chk("flush_ovalid", out_valid, 0);
        @(posedge clk); #2;
        chk("flush_drop", occupancy, 0);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 3; k++) push(addi(13, 0, 400 + k));
        chk("pre_rst_occ", occupancy, 2);
        #4; rst_n = 1'b0; #1;
        chk("arst_ovalid", out_valid, 0);
        chk("arst_pc", out_pc, 0);
        chk("arst_imm", out_imm, 0);
        chk("arst_rd", out_rd_addr, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_stall", stall_cnt, 0);
        @(posedge clk); #2; rst_n = 1'b1;
        out_ready = 1;
        push(addi(14, 0, 42));
        @(posedge clk); #2;
        chk("post_rst_imm", out_imm, 42);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
